// File: rtl/fifo_read_logic.sv
// Read-side pointer/flag controller of a dual-clock FIFO (read clock domain).
// Keeps binary and Gray read pointers and derives empty, occupancy and underflow flags.
module fifo_read_logic #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned PTR_SZ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ-1:0] wq2_waddr_gray,
  output logic              rempty,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ-1:0] raddr_gray,
  output logic [PTR_SZ-1:0] rcount,
  output logic              runderflow,
  output logic [1:0]        rstate
);

  localparam int unsigned CW = PTR_SZ + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EMPTY = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PTR_SZ-1:0] waddr_bin;
  logic [PTR_SZ-1:0] raddr_next;
  logic [PTR_SZ-1:0] count_next;
  logic [CW-1:0]     diff;
  logic              pop;
  logic              empty_next;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    waddr_bin = '0;
    for (int i = 0; i < int'(PTR_SZ); i++) begin
      waddr_bin[i] = ^(wq2_waddr_gray >> i);
    end
  end

  assign pop = rinc & ~rempty;

  // >= keeps the pointer inside 0..DEPTH-1 even if it were ever corrupted
  always_comb begin
    raddr_next = raddr;
    if (pop) begin
      if (raddr >= PTR_SZ'(DEPTH - 1)) raddr_next = '0;
      else                             raddr_next = raddr + PTR_SZ'(1);
    end
  end

  assign empty_next = (raddr_next == waddr_bin);

  always_comb begin
    diff       = {1'b0, waddr_bin} - {1'b0, raddr_next};
    count_next = diff[PTR_SZ-1:0];
    if (diff[CW-1]) begin
      count_next = PTR_SZ'(diff + CW'(DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty_next) state_next = READ;
      READ:    if (empty_next)  state_next = EMPTY;
      EMPTY:   if (!empty_next) state_next = READ;
      default: state_next = IDLE;
    endcase
  end

  // FSM output: the state register is exported directly
  always_comb begin
    rstate = state;
  end

  // Pointer and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr      <= '0;
      raddr_gray <= '0;
      rempty     <= 1'b1;
      read_en    <= 1'b0;
      rcount     <= '0;
      runderflow <= 1'b0;
    end else begin
      raddr      <= raddr_next;
      raddr_gray <= raddr_next ^ (raddr_next >> 1);
      rempty     <= empty_next;
      read_en    <= ~empty_next;
      rcount     <= count_next;
      runderflow <= rinc & rempty;
    end
  end

endmodule

// File: tb/tb_fifo_read_logic.sv
// Directed, table-driven self-checking bench for fifo_read_logic (DEPTH=3, PTR_SZ=2).
module tb_fifo_read_logic;

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned PTR_SZ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rinc;
  logic [PTR_SZ-1:0] wq2;
  logic              rempty;
  logic              read_en;
  logic [PTR_SZ-1:0] raddr;
  logic [PTR_SZ-1:0] raddr_gray;
  logic [PTR_SZ-1:0] rcount;
  logic              runderflow;
  logic [1:0]        rstate;

  fifo_read_logic #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) dut (
    .clk           (clk),
    .rst           (rst),
    .rinc          (rinc),
    .wq2_waddr_gray(wq2),
    .rempty        (rempty),
    .read_en       (read_en),
    .raddr         (raddr),
    .raddr_gray    (raddr_gray),
    .rcount        (rcount),
    .runderflow    (runderflow),
    .rstate        (rstate)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rinc;
    logic [1:0] wq2;
    logic       e_empty;
    logic       e_ren;
    logic [1:0] e_raddr;
    logic [1:0] e_gray;
    logic [1:0] e_cnt;
    logic       e_uf;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];
  int   split_idx;
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string name, input logic ri, input logic [1:0] w,
                              input logic em, input logic re, input logic [1:0] ra,
                              input logic [1:0] rg, input logic [1:0] cnt,
                              input logic uf, input logic [1:0] st);
    vec_t v;
    v.name = name; v.rinc = ri; v.wq2 = w;
    v.e_empty = em; v.e_ren = re; v.e_raddr = ra; v.e_gray = rg;
    v.e_cnt = cnt; v.e_uf = uf; v.e_st = st;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic em, input logic re,
                           input logic [1:0] ra, input logic [1:0] rg,
                           input logic [1:0] cnt, input logic uf, input logic [1:0] st);
    chk({tag, ".rempty"},     8'(rempty),     8'(em));
    chk({tag, ".read_en"},    8'(read_en),    8'(re));
    chk({tag, ".raddr"},      8'(raddr),      8'(ra));
    chk({tag, ".raddr_gray"}, 8'(raddr_gray), 8'(rg));
    chk({tag, ".rcount"},     8'(rcount),     8'(cnt));
    chk({tag, ".runderflow"}, 8'(runderflow), 8'(uf));
    chk({tag, ".rstate"},     8'(rstate),     8'(st));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rinc = v.rinc;
    wq2  = v.wq2;
    @(posedge clk);
    #1;
    check_all(v.name, v.e_empty, v.e_ren, v.e_raddr, v.e_gray, v.e_cnt, v.e_uf, v.e_st);
  endtask

  initial begin
    //    name        rinc wq2    em re raddr  gray   cnt    uf st
    for (int i = 0; i < 5; i++)
      add("idle",     0, 2'b00,  1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b00);
    add("wr1",        0, 2'b01,  0, 1, 2'd0, 2'b00, 2'd1, 0, 2'b01);
    add("pop1",       1, 2'b01,  1, 0, 2'd1, 2'b01, 2'd0, 0, 2'b10);
    add("wr2",        0, 2'b11,  0, 1, 2'd1, 2'b01, 2'd1, 0, 2'b01);
    add("wr_wrap",    0, 2'b00,  0, 1, 2'd1, 2'b01, 2'd2, 0, 2'b01);
    add("pop2",       1, 2'b00,  0, 1, 2'd2, 2'b11, 2'd1, 0, 2'b01);
    add("pop_wrap",   1, 2'b00,  1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b10);
    add("under1",     1, 2'b00,  1, 0, 2'd0, 2'b00, 2'd0, 1, 2'b10);
    add("under2",     1, 2'b00,  1, 0, 2'd0, 2'b00, 2'd0, 1, 2'b10);
    add("under_end",  0, 2'b00,  1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b10);
    add("sim_pre",    0, 2'b01,  0, 1, 2'd0, 2'b00, 2'd1, 0, 2'b01);
    add("sim_evt",    1, 2'b11,  0, 1, 2'd1, 2'b01, 2'd1, 0, 2'b01);
    add("to_raddr2",  1, 2'b00,  0, 1, 2'd2, 2'b11, 2'd1, 0, 2'b01);
    split_idx = vecs.size();
    add("post_wr",    0, 2'b01,  0, 1, 2'd0, 2'b00, 2'd1, 0, 2'b01);
    add("post_pop",   1, 2'b01,  1, 0, 2'd1, 2'b01, 2'd0, 0, 2'b10);

    rst  = 1'b1;
    rinc = 1'b0;
    wq2  = 2'b00;
    #1 rst = 1'b0;
    #1 check_all("rst_async", 1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b00);
    repeat (2) @(posedge clk);
    #1 check_all("rst_hold", 1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < split_idx; i++) apply(vecs[i]);

    // Reset asserted between edges while a pop is pending
    @(negedge clk);
    rinc = 1'b1;
    wq2  = 2'b00;
    #2 rst = 1'b0;
    #1 check_all("rst_mid", 1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b00);
    @(posedge clk);
    #1 check_all("rst_mid_edge", 1, 0, 2'd0, 2'b00, 2'd0, 0, 2'b00);
    @(negedge clk);
    rinc = 1'b0;
    rst  = 1'b1;

    for (int i = split_idx; i < vecs.size(); i++) apply(vecs[i]);

    // Out-of-contract write pointer (decodes to 3): raddr must still wrap at DEPTH-1
    @(negedge clk);
    rinc = 1'b0;
    wq2  = 2'b10;
    @(posedge clk);
    #1 chk("ooc.rempty", 8'(rempty), 8'd0);
    begin
      logic [1:0] exp_ra [3];
      logic [1:0] exp_rg [3];
      exp_ra[0] = 2'd2; exp_rg[0] = 2'b11;
      exp_ra[1] = 2'd0; exp_rg[1] = 2'b00;
      exp_ra[2] = 2'd1; exp_rg[2] = 2'b01;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        rinc = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("ooc.raddr%0d", k),      8'(raddr),      8'(exp_ra[k]));
        chk($sformatf("ooc.raddr_gray%0d", k), 8'(raddr_gray), 8'(exp_rg[k]));
      end
    end
    @(negedge clk);
    rinc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_logic.md
# fifo_read_logic

Read-side pointer and flag controller for the dual-clock FIFO, running entirely in the read clock domain. It keeps the binary read address and its Gray-coded copy, which is exported for synchronisation into the write domain. It decodes the already-synchronised Gray write pointer, generates empty, read-enable, occupancy and underflow indications, and tracks fill state with a small FSM.

## Interface
- DEPTH, 3: number of FIFO entries. Legal range is 2..2^PTR_SZ.
- PTR_SZ, 2: width in bits of an entry index.
- clk  input  1: read-domain clock, rising edge.
- rst  input  1: asynchronous, active-low reset.
- rinc  input  1: pop request, sampled at posedge clk.
- wq2_waddr_gray  input  PTR_SZ: write pointer, Gray-coded, already double-synchronised into clk.
- rempty  output  1: FIFO empty (registered).
- read_en  output  1: head entry valid; always equal to !rempty (registered).
- raddr  output  PTR_SZ: binary address of the head entry; drives the RAM read port.
- raddr_gray  output  PTR_SZ: equal to (raddr>>1)^raddr; goes to the write-domain synchroniser.
- rcount  output  PTR_SZ: number of entries held (registered).
- runderflow  output  1: one-cycle pulse on a rejected pop.
- rstate  output  2: FSM state. IDLE=00, READ=01, EMPTY=10.

## Operation
- **Gray decode** (combinational): waddr_bin[i] = XOR of wq2_waddr_gray[PTR_SZ-1:i].
- **Pop acceptance**: a pop is accepted at a posedge when rinc=1 and rempty=0.
  - Data is taken from the RAM at the current raddr.
  - raddr_next = (raddr==DEPTH-1) ? 0 : raddr+1.
  - Without an accepted pop, raddr_next = raddr.
- **Rejected pop**: rinc=1 with rempty=1 sets runderflow=1 for exactly one cycle. raddr is unchanged.
- **Registered updates** at each posedge:
  - raddr <= raddr_next
  - raddr_gray <= gray(raddr_next)
  - rempty <= (raddr_next == waddr_bin)
  - read_en <= !(raddr_next == waddr_bin)
  - rcount <= (waddr_bin - raddr_next) mod DEPTH, computed at PTR_SZ+1 bits: add DEPTH when the difference is negative.
- **Full convention**: the write side declares full at (waddr+1)%DEPTH == raddr. At most DEPTH-1 entries are held, so rcount never exceeds DEPTH-1.
- **FSM** (next state uses empty_next = (raddr_next==waddr_bin)):
  - IDLE -> READ when !empty_next; otherwise stays in IDLE.
  - READ -> EMPTY when empty_next; otherwise stays in READ.
  - EMPTY -> READ when !empty_next; otherwise stays in EMPTY.
  - Encoding 11 is unreachable and returns to IDLE.
- **Out-of-contract input**: a decoded waddr_bin >= DEPTH is out of contract. raddr must still never leave the range 0..DEPTH-1.

## Timing
- **Reset** (rst=0, asynchronous): all outputs take their reset values immediately, independent of clk:
  - rempty=1, read_en=0, raddr=0, raddr_gray=0, rcount=0, runderflow=0, rstate=IDLE.
  - Reset during an active pop discards the pop.
- **Write-pointer latency**: a change on wq2_waddr_gray is reflected in rempty, read_en, rcount and rstate at the first posedge at which it is sampled. That is one cycle of latency, on top of the external two-flop synchroniser.
- **Pop latency**: raddr, raddr_gray, rempty and rcount reflect an accepted pop at the same posedge.
- **Simultaneous pop and write-pointer change**:
  - Acceptance uses the current registered rempty.
  - The new flags use raddr_next together with the newly sampled waddr_bin.
- **Pointer wrap**: DEPTH-1 -> 0. raddr_gray wraps to 0 in the same edge.
- **Outputs**: all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
All scenarios use DEPTH=3, PTR_SZ=2. Gray codes: 0=00, 1=01, 2=11.
1. **Reset**: hold rst=0, then release with wq2=00 and rinc=0 -> rempty=1, read_en=0, raddr=0, rcount=0, rstate=00. Outputs hold for 5 cycles.
2. **Single pop**: set wq2=01 -> after 1 edge, rempty=0, read_en=1, rcount=1, rstate=01. Pulse rinc for one cycle -> raddr=1, raddr_gray=01, rempty=1, rcount=0, rstate=10.
3. **Wrap**: raddr=1, wq2 steps 11 then 00 -> rcount=1 then 2. Pop twice -> raddr goes 2 (gray 11), then 0 (gray 00), ending with rempty=1 and rcount=0.
4. **Underflow**: rempty=1, rinc=1 for 2 cycles -> runderflow=1 on each of those edges, raddr unchanged, rempty stays 1. runderflow=0 the cycle after rinc drops.
5. **Simultaneous events**: raddr=0, wq2=01; wq2 changes to 11 at the same edge that samples rinc=1 -> raddr=1, rempty=0, rcount=1, rstate=01.
6. **Async reset mid-operation**: raddr=2, rcount=1; drive rst low between clock edges -> all outputs reach their reset values before the next posedge. Normal operation resumes after release.
